// File: rtl/conv_detect_core.sv
// conv_detect_core: per-channel sliding-window sum (K = 3/5/7/9) with a
// peak/direction detector across CHANNELS microphone inputs.
// Optional build macro: CONV_DETECT_STICKY_EN. When it is defined, detected
// latches on the first hit and direction/peak_sum freeze until reset or FLUSH.

// One channel's sample history and window sum.
module conv_detect_lane #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = DATA_W + 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc,
  input  logic              clr,
  input  logic [3:0]        k_m1,
  input  logic [DATA_W-1:0] sample,
  output logic [ACC_W-1:0]  sum
);
  // The 9-deep window is the incoming sample plus 8 stored ones.
  // The sum covers the accept in progress, so outputs register on the accepting edge.
  logic [7:0][DATA_W-1:0] hist;

  // Incoming sample plus the newest K-1 stored samples.
  always_comb begin
    sum = ACC_W'(sample);
    for (int i = 0; i < 8; i++)
      if (4'(i) < k_m1) sum = sum + ACC_W'(hist[i]);
  end

  // Shift history on accept; FLUSH zeroes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    hist <= '0;
    else if (clr) hist <= '0;
    else if (acc) hist <= {hist[6:0], sample};
  end
endmodule

module conv_detect_core #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 4,
  parameter int ACC_W    = DATA_W + 4,
  parameter int CH_W     = $clog2(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] sample_in,
  input  logic [1:0]                 kernel_size,
  input  logic [ACC_W-1:0]           threshold,
  output logic                       out_valid,
  output logic                       detected,
  output logic [CH_W-1:0]            direction,
  output logic [ACC_W-1:0]           peak_sum
);
  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t                       state;
  logic [1:0]                   ks_lat;
  logic [3:0]                   cnt;
  logic [3:0]                   k_val, k_m1, cnt_nxt;
  logic                         accept, clr, hit_k;
  logic [CHANNELS-1:0][ACC_W-1:0] sums;
  logic [ACC_W-1:0]             best_sum;
  logic [CH_W-1:0]              best_idx;

  assign in_ready = (state != FLUSH);
  assign accept   = in_valid && in_ready;
  assign clr      = (state == FLUSH);
  assign k_val    = {1'b0, ks_lat, 1'b0} + 4'd3;
  assign k_m1     = k_val - 4'd1;
  assign cnt_nxt  = cnt + 4'd1;
  assign hit_k    = (cnt_nxt >= k_val);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    conv_detect_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .acc    (accept),
      .clr    (clr),
      .k_m1   (k_m1),
      .sample (sample_in[c*DATA_W +: DATA_W]),
      .sum    (sums[c])
    );
  end

  // Largest window sum; strict > keeps ties on the lowest channel.
  always_comb begin
    best_sum = sums[0];
    best_idx = '0;
    for (int c = 1; c < CHANNELS; c++)
      if (sums[c] > best_sum) begin
        best_sum = sums[c];
        best_idx = CH_W'(c);
      end
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      ks_lat    <= 2'b00;
      cnt       <= '0;
      out_valid <= 1'b0;
      detected  <= 1'b0;
      direction <= '0;
      peak_sum  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        FLUSH: begin
          state <= FILL;
          cnt   <= '0;
`ifdef CONV_DETECT_STICKY_EN
          detected <= 1'b0;
`endif
        end
        default: begin
          if (accept) begin
            // Saturate at the deepest window; only >= K matters afterwards.
            if (cnt < 4'd9) cnt <= cnt_nxt;
            if (hit_k) begin
              state     <= RUN;
              out_valid <= 1'b1;
`ifdef CONV_DETECT_STICKY_EN
              if (!detected) begin
`else
              begin
`endif
                peak_sum  <= best_sum;
                direction <= best_idx;
                detected  <= (best_sum >= threshold);
              end
            end
          end
          // A kernel change is the last thing this cycle; the FLUSH cycle then clears.
          if (kernel_size != ks_lat) begin
            state  <= FLUSH;
            ks_lat <= kernel_size;
          end
        end
      endcase
    end
  end
endmodule
